// File: rtl/sram_puf_reader_pkg.sv
// Shared types and widths for the SRAM PUF read-side initiator.
// The state enum and PUF bus widths live here so the interface, top and bench agree.
package sram_puf_pkg;

    localparam int PUF_ADDR_W = 32;
    localparam int PUF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        DRAIN_A,
        RD_B,
        DRAIN_B,
        DONE
    } state_t;

    // Width needed to count every differing bit of one region without saturation.
    function automatic int hd_width(input int num_bytes);
        return $clog2(num_bytes * PUF_DATA_W + 1);
    endfunction

endpackage

// File: rtl/sram_puf_reader_if.sv
// Request, PUF read bus and response handshake of the SRAM PUF reader.
// master is the reader itself; slave is the controller/PUF-array side.
interface sram_puf_reader_if
    import sram_puf_pkg::*;
#(
    parameter int ADDR_W    = PUF_ADDR_W,
    parameter int DATA_W    = PUF_DATA_W,
    parameter int NUM_BYTES = 16
);

    localparam int HD_W = hd_width(NUM_BYTES);

    logic                        start;
    logic                        cmp_en;
    logic [ADDR_W-1:0]           base_a;
    logic [ADDR_W-1:0]           base_b;
    logic                        busy;

    logic [ADDR_W-1:0]           puf_addr;
    logic                        puf_re;
    logic [DATA_W-1:0]           puf_q;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [NUM_BYTES*DATA_W-1:0] resp_data;
    logic [HD_W-1:0]             resp_hd;

    modport master (
        input  start, cmp_en, base_a, base_b, puf_q, resp_ready,
        output busy, puf_addr, puf_re, resp_valid, resp_data, resp_hd
    );

    modport slave (
        output start, cmp_en, base_a, base_b, puf_q, resp_ready,
        input  busy, puf_addr, puf_re, resp_valid, resp_data, resp_hd
    );

endinterface

// File: rtl/sram_puf_reader_popcount8.sv
// Combinational ones-count of one byte, used to accumulate the A/B Hamming distance.
module popcount8 (
    input  logic [7:0] din,
    output logic [3:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, din[i]};
        end
    end

endmodule

// File: rtl/sram_puf_reader.sv
// Sweeps region A (and optionally region B) of the PUF array, packs region A into a
// response word and accumulates the bitwise Hamming distance of B against A.
module sram_puf_reader
    import sram_puf_pkg::*;
#(
    parameter int ADDR_W    = PUF_ADDR_W,
    parameter int DATA_W    = PUF_DATA_W,
    parameter int NUM_BYTES = 16
) (
    input logic               clk,
    input logic               rst_n,
    sram_puf_reader_if.master bus
);

    localparam int HD_W  = hd_width(NUM_BYTES);
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t                      state, state_nxt;
    logic                        cmp_q;
    logic [ADDR_W-1:0]           base_a_q, base_b_q;
    logic [IDX_W-1:0]            issue_idx;
    logic                        s1_vld, s2_vld, s1_b, s2_b;
    logic [IDX_W-1:0]            s1_idx, s2_idx;
    logic [ADDR_W-1:0]           addr_q;
    logic                        re_q;
    logic [NUM_BYTES*DATA_W-1:0] data_q;
    logic [HD_W-1:0]             hd_q;
    logic [DATA_W-1:0]           stored_byte;
    logic [3:0]                  byte_hd;
    logic                        issuing, last_issue, pipe_empty, accept;
    logic                        busy_c, valid_c;

    always_comb begin
        issuing     = (state == RD_A) || (state == RD_B);
        last_issue  = issuing && (issue_idx == LAST_IDX);
        pipe_empty  = !s1_vld && !s2_vld;
        accept      = (state == IDLE) && bus.start;
        stored_byte = data_q[s2_idx*DATA_W +: DATA_W];
    end

    popcount8 u_popcount (
        .din   (bus.puf_q ^ stored_byte),
        .count (byte_hd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        valid_c   = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_nxt = RD_A;
            RD_A:    begin busy_c = 1'b1; if (last_issue) state_nxt = DRAIN_A; end
            DRAIN_A: begin busy_c = 1'b1; if (pipe_empty) state_nxt = cmp_q ? RD_B : DONE; end
            RD_B:    begin busy_c = 1'b1; if (last_issue) state_nxt = DRAIN_B; end
            DRAIN_B: begin busy_c = 1'b1; if (pipe_empty) state_nxt = DONE; end
            DONE:    begin valid_c = 1'b1; if (bus.resp_ready) state_nxt = IDLE; end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue side plus the two-stage tag pipe that lines up with the PUF's read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_idx <= '0;
            addr_q    <= '0;
            re_q      <= 1'b0;
            s1_vld    <= 1'b0;
            s1_idx    <= '0;
            s1_b      <= 1'b0;
            s2_vld    <= 1'b0;
            s2_idx    <= '0;
            s2_b      <= 1'b0;
        end else begin
            re_q   <= issuing;
            s1_vld <= issuing;
            s1_idx <= issue_idx;
            s1_b   <= (state == RD_B);
            s2_vld <= s1_vld;
            s2_idx <= s1_idx;
            s2_b   <= s1_b;
            if (issuing) begin
                addr_q    <= ((state == RD_B) ? base_b_q : base_a_q) + ADDR_W'(issue_idx);
                issue_idx <= last_issue ? '0 : issue_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q    <= 1'b0;
            base_a_q <= '0;
            base_b_q <= '0;
            data_q   <= '0;
            hd_q     <= '0;
        end else if (accept) begin
            cmp_q    <= bus.cmp_en;
            base_a_q <= bus.base_a;
            base_b_q <= bus.base_b;
            hd_q     <= '0;
        end else if (s2_vld) begin
            if (s2_b) hd_q <= hd_q + HD_W'(byte_hd);
            else      data_q[s2_idx*DATA_W +: DATA_W] <= bus.puf_q;
        end
    end

    assign bus.puf_addr   = addr_q;
    assign bus.puf_re     = re_q;
    assign bus.busy       = busy_c;
    assign bus.resp_valid = valid_c;
    assign bus.resp_data  = data_q;
    assign bus.resp_hd    = hd_q;

endmodule

// File: tb/tb_sram_puf_reader.sv
// Bench for sram_puf_reader: models the hard-coded PUF array and predicts every
// response from the array contents with plain byte arithmetic.
module tb_sram_puf_reader;
    import sram_puf_pkg::*;

    localparam int NB  = 16;
    localparam int DW  = NB * 8;
    localparam logic [7:0] SEED [16] = '{8'ha3, 8'h0a, 8'h22, 8'h3b, 8'hf7, 8'h28, 8'hb1, 8'hd1,
                                         8'h5c, 8'h6e, 8'h1f, 8'hc3, 8'h7d, 8'he5, 8'h3e, 8'h99};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_puf_reader_if #(.ADDR_W(32), .DATA_W(8), .NUM_BYTES(NB)) bus ();

    sram_puf_reader #(.ADDR_W(32), .DATA_W(8), .NUM_BYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  rom [256];
    logic [31:0] issued [$];
    int checks = 0;
    int fails  = 0;

    function automatic logic [7:0] puf_byte(input logic [31:0] a);
        if (a < 32'd256) return rom[a[7:0]];
        return 8'h00;
    endfunction

    // PUF array: address sampled on the edge, data available one clock later.
    always @(posedge clk) begin
        if (bus.puf_re) begin
            bus.puf_q <= puf_byte(bus.puf_addr);
            issued.push_back(bus.puf_addr);
        end
    end

    function automatic logic [DW-1:0] model_data(input logic [31:0] a);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NB; k++) d[8*k +: 8] = puf_byte(a + 32'(k));
        return d;
    endfunction

    function automatic int model_hd(input logic [31:0] a, input logic [31:0] b);
        int s;
        s = 0;
        for (int k = 0; k < NB; k++) s += $countones(puf_byte(a + 32'(k)) ^ puf_byte(b + 32'(k)));
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic cmp, input logic [31:0] a, input logic [31:0] b,
                                 output int lat);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.cmp_en = cmp;
        bus.base_a = a;
        bus.base_b = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cmp_en = 1'($urandom);
        bus.base_a = $urandom;
        bus.base_b = $urandom;
        lat = 0;
        while (!bus.resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_addr"},  128'(bus.puf_addr),   128'(0));
        checkOutput({tag, "_re"},    128'(bus.puf_re),     128'(0));
        checkOutput({tag, "_busy"},  128'(bus.busy),       128'(0));
        checkOutput({tag, "_valid"}, 128'(bus.resp_valid), 128'(0));
        checkOutput({tag, "_data"},  128'(bus.resp_data),  128'(0));
        checkOutput({tag, "_hd"},    128'(bus.resp_hd),    128'(0));
    endtask

    task automatic handshake(input string tag);
        bus.resp_ready = 1'b1;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.start      = 1'b0;
        checkOutput({tag, "_valid_drop"}, 128'(bus.resp_valid), 128'(0));
        @(negedge clk);
        checkOutput({tag, "_idle"}, 128'(bus.busy), 128'(0));
    endtask

    initial begin
        int lat;
        int mark;
        int exp_hd;
        logic [31:0] a, b;
        logic cmp;
        logic saw_valid;
        logic [DW-1:0] exp_data;

        for (int k = 0; k < 256; k++) rom[k] = 8'($urandom);
        for (int k = 0; k < 16; k++) begin
            rom[k]      = SEED[k];
            rom[16 + k] = 8'h00;
            rom[32 + k] = SEED[k];
            rom[48 + k] = 8'h00;
        end
        rom[35] = 8'h3a;

        bus.start = 1'b0; bus.cmp_en = 1'b0; bus.base_a = '0; bus.base_b = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;

        // Region A only from address 0
        mark = issued.size();
        applyStimulus(1'b0, 32'd0, 32'd0, lat);
        checkOutput("a_only_latency", 128'(lat), 128'(19));
        checkOutput("a_only_valid", 128'(bus.resp_valid), 128'(1));
        checkOutput("a_only_busy", 128'(bus.busy), 128'(0));
        checkOutput("a_only_byte0", 128'(bus.resp_data[7:0]), 128'(8'ha3));
        checkOutput("a_only_byte3", 128'(bus.resp_data[31:24]), 128'(8'h3b));
        checkOutput("a_only_byte15", 128'(bus.resp_data[127:120]), 128'(8'h99));
        checkOutput("a_only_data", bus.resp_data, model_data(32'd0));
        checkOutput("a_only_hd", 128'(bus.resp_hd), 128'(0));
        checkOutput("a_only_reads", 128'(issued.size() - mark), 128'(NB));
        handshake("a_only");

        // Compare against the copy with one flipped bit
        applyStimulus(1'b1, 32'd0, 32'd32, lat);
        checkOutput("cmp32_latency", 128'(lat), 128'(38));
        checkOutput("cmp32_hd", 128'(bus.resp_hd), 128'(1));
        checkOutput("cmp32_data", bus.resp_data, model_data(32'd0));
        handshake("cmp32");

        // Compare against an all-zero region, then hold the response unaccepted
        applyStimulus(1'b1, 32'd0, 32'd48, lat);
        checkOutput("cmp48_hd", 128'(bus.resp_hd), 128'(68));
        checkOutput("cmp48_model_hd", 128'(bus.resp_hd), 128'(model_hd(32'd0, 32'd48)));
        for (int c = 0; c < 10; c++) begin
            bus.start  = (c == 3) || (c == 6);
            bus.cmp_en = 1'b0;
            bus.base_a = 32'd100;
            @(negedge clk);
            checkOutput("hold_valid", 128'(bus.resp_valid), 128'(1));
            checkOutput("hold_data", bus.resp_data, model_data(32'd0));
            checkOutput("hold_hd", 128'(bus.resp_hd), 128'(68));
        end
        bus.start = 1'b0;
        handshake("hold");
        checkOutput("after_hs_data", bus.resp_data, model_data(32'd0));
        checkOutput("after_hs_hd", 128'(bus.resp_hd), 128'(68));

        // Reset while region A is being swept
        @(negedge clk);
        bus.start = 1'b1; bus.cmp_en = 1'b1; bus.base_a = 32'd0; bus.base_b = 32'd32;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("midsweep_busy", 128'(bus.busy), 128'(1));
        rst_n = 1'b0;
        #1;
        checkReset("midsweep_reset");
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (bus.resp_valid) saw_valid = 1'b1;
        end
        checkOutput("midsweep_no_valid", 128'(saw_valid), 128'(0));
        applyStimulus(1'b0, 32'd0, 32'd0, lat);
        checkOutput("post_reset_latency", 128'(lat), 128'(19));
        checkOutput("post_reset_data", bus.resp_data, model_data(32'd0));
        handshake("post_reset");

        // Address wrap across the top of the address space
        mark = issued.size();
        applyStimulus(1'b0, 32'hffff_fff8, 32'd0, lat);
        checkOutput("wrap_data_hi", 128'(bus.resp_data[127:64]), 128'(64'h99_3e_e5_7d_c3_1f_6e_5c ^ 64'h99_3e_e5_7d_c3_1f_6e_5c ^ 64'hd1_b1_28_f7_3b_22_0a_a3));
        checkOutput("wrap_data", bus.resp_data, model_data(32'hffff_fff8));
        checkOutput("wrap_addr_top", 128'(issued[mark + 7]), 128'(32'hffff_ffff));
        checkOutput("wrap_addr_zero", 128'(issued[mark + 8]), 128'(32'h0));
        handshake("wrap");

        // Randomised regions, including ones straddling the wrap point
        for (int t = 0; t < 8; t++) begin
            cmp = 1'($urandom);
            a   = (t % 3 == 2) ? 32'hffff_fff0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 250));
            b   = 32'($urandom_range(0, 250));
            exp_data = model_data(a);
            exp_hd   = cmp ? model_hd(a, b) : 0;
            applyStimulus(cmp, a, b, lat);
            checkOutput("rand_latency", 128'(lat), 128'(cmp ? 2*NB + 6 : NB + 3));
            checkOutput("rand_data", bus.resp_data, exp_data);
            checkOutput("rand_hd", 128'(bus.resp_hd), 128'(exp_hd));
            handshake("rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
